bus_arbiter8: RTL
=================

// Module: bus_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one bus among 8 requesters; one-hot grant
//  matches the 3-to-8 decoder select format (gnt == 1 << gnt_idx).
//  Sits between requester ports and the bus select decode; the owner holds
//  the bus while its req stays high.
// PARAMETERS
//  MAX_BURST  16  cycles an owner may hold the bus when others wait (timeout only)
//  CNT_W      5   width of burst counter; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  clk      in   1  system clock, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  req      in   8  request per master, level, held for whole transfer
//  gnt      out  8  one-hot grant, registered; all-zero when bus idle
//  gnt_idx  out  3  encoded index of current owner (valid when gnt_vld)
//  gnt_vld  out  1  high while any grant is asserted (== |gnt)
//  preempt  out  1  1-cycle pulse on forced release (timeout build only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, gnt=0, gnt_idx=0,
//    gnt_vld=0, preempt=0, last=7 (so master 0 wins first), cnt=0.
//  - States: IDLE (no owner), GRANT (owner = gnt_idx).
//  - IDLE: at each edge, if |req: winner = first set bit searching
//    last+1, last+2 ... wrapping modulo 8; gnt<=1<<winner, gnt_idx<=winner,
//    last<=winner, cnt<=0, ->GRANT. If req==0 stay IDLE, outputs unchanged(0).
//  - Latency: req sampled high at edge k in IDLE -> gnt high after edge k.
//  - GRANT: while req[gnt_idx]==1 hold gnt, cnt increments (saturates).
//    req[gnt_idx]==0 at edge -> gnt<=0, ->IDLE. Exactly one cycle with
//    gnt==0 between consecutive owners (bus turnaround).
//  - Non-owner req changes in GRANT ignored until return to IDLE.
//  - Owner drops and re-raises: rejoins round robin at lowest priority
//    (last == its index), wins again only if no other req.
//  - Only one gnt bit ever high; gnt never changes except IDLE<->GRANT edges.
//  - All 8 requesting continuously: grants 0,1,...,7,0 in order.
//  - Reset mid-grant: gnt drops to 0 immediately (async), last returns to 7.
//  - req bits with X treated as don't care by design; bench drives 0/1 only.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//   - In GRANT, if cnt==MAX_BURST-1 and any other req bit set at edge:
//     gnt<=0, preempt<=1 for one cycle, ->IDLE; last stays = owner so next
//     arbitration favours others. If no other req, cnt<=0, owner keeps bus.
//  BUS_ARB_TIMEOUT_EN undefined:
//   - No counter compare; owner holds indefinitely; preempt tied 0;
//     MAX_BURST/CNT_W unused.
// TESTING
//  1 reset, req=8'h00 -> gnt=0, gnt_vld=0 for 10 cycles.
//  2 req=8'hFF held -> owners drop in turn after 3 cycles each;
//    grant order 0..7 then 0, one zero-gnt cycle between each.
//  3 last=2, req=8'h05 (0 and 2) -> gnt=8'h01 (idx 0 via wrap), then 8'h04.
//  4 owner 3 holding, req[5] rises mid-grant -> no change until req[3]
//    drops; then 1 idle cycle, gnt=8'h20, gnt_idx=5.
//  5 TIMEOUT_EN, MAX_BURST=16: req=8'h03 held -> owner 0 for 16 cycles,
//    preempt pulse, idle cycle, gnt=8'h02; req=8'h01 only -> no preempt.
//  6 rst_n low during GRANT -> gnt=0 same cycle; after release req=8'h80
//    -> gnt=8'h80 one edge later.

Source files
------------

// File: rtl/bus_arbiter8_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter8_if
//   Request/grant bundle between eight bus requesters and bus_arbiter8.
//
//   Signals
//     req      [7:0]  level request per master, held for the whole transfer
//     gnt      [7:0]  one-hot grant, all-zero while the bus is idle
//     gnt_idx  [2:0]  encoded owner index, meaningful while gnt_vld is high
//     gnt_vld         high while any grant bit is set
//     preempt         one-cycle pulse on a forced release (timeout build only)
//
//   Modports
//     slave   arbiter side: samples req, drives the grant outputs
//     master  requester side: drives req, observes the grant outputs
// ---------------------------------------------------------------------------
interface bus_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output preempt
    );

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  preempt
    );
endinterface : bus_arbiter8_if

// File: rtl/bus_arbiter8.sv
// ---------------------------------------------------------------------------
// bus_arbiter8
//   Round-robin arbiter sharing one bus among eight requesters. The grant is
//   one-hot and matches the select format of a 3-to-8 decoder
//   (gnt == 1 << gnt_idx). An owner keeps the bus while its request stays
//   high; releasing it always leaves one idle (all-zero grant) cycle before
//   the next owner is granted.
//
//   Ports
//     clk      in   rising-edge system clock
//     rst_n    in   asynchronous active-low reset (release synchronised
//                   externally)
//     bus      slave modport of bus_arbiter8_if (req in; gnt, gnt_idx,
//                   gnt_vld, preempt out)
//
//   Parameters
//     MAX_BURST  cycles an owner may hold the bus while others wait
//                (only enforced in the timeout build)
//     CNT_W      burst counter width, 2**CNT_W must exceed MAX_BURST
//
//   Build option
//     BUS_ARB_TIMEOUT_EN  when defined, an owner that has held the bus for
//                         MAX_BURST cycles while another master is waiting is
//                         forced off and preempt pulses for one cycle. When
//                         undefined, owners hold indefinitely and preempt
//                         stays low.
// ---------------------------------------------------------------------------
module bus_arbiter8 #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter8_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    // Counter value reached on the last cycle of a full burst.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_q;
    logic [7:0]       gnt_q;
    logic [2:0]       gnt_idx_q;
    logic             gnt_vld_q;
    logic             preempt_q;
    logic [2:0]       last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             win_found;

    // Round-robin search: first requesting master after the last winner,
    // wrapping modulo 8. The last winner itself is checked last, so it only
    // wins again when nobody else is requesting.
    always_comb begin
        win_idx   = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!win_found && bus.req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic others_waiting;
    // Any request other than the owner's (gnt_q is one-hot in GRANT).
    assign others_waiting = |(bus.req & ~gnt_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            preempt_q <= 1'b0;
            last_q    <= 3'd7;
            cnt_q     <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        gnt_q     <= 8'b1 << win_idx;
                        gnt_idx_q <= win_idx;
                        gnt_vld_q <= 1'b1;
                        last_q    <= win_idx;
                        cnt_q     <= '0;
                        state_q   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[gnt_idx_q]) begin
                        gnt_q     <= '0;
                        gnt_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        // last_q already holds the owner, so the following
                        // arbitration favours the masters that were waiting.
                        if (others_waiting) begin
                            gnt_q     <= '0;
                            gnt_vld_q <= 1'b0;
                            preempt_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
`endif
                    else if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_q     <= '0;
                    gnt_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.preempt = preempt_q;

endmodule : bus_arbiter8
